// File: rtl/mux4_arb_pkg.sv
// Shared types and sizes for the four-way round-robin output mux.
package mux4_arb_pkg;
    localparam int NREQ  = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;
endpackage

// File: rtl/mux4_data_sel.sv
// W-bit 4:1 data mux steered by the registered grant index.
module mux4_data_sel
    import mux4_arb_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [SEL_W-1:0]  sel,
    input  logic [NREQ*W-1:0] data_in,
    output logic [W-1:0]      out_data
);
    always_comb begin
        out_data = data_in[sel*W +: W];
    end
endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin burst arbiter sharing one valid/ready channel between four
// requesters; a grant lasts until last, the beat limit, or a request drop.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int W         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] data_in,
    input  logic [NREQ-1:0]   last,
    input  logic              out_ready,
    output logic [NREQ-1:0]   gnt,
    output logic [SEL_W-1:0]  out_sel,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic              busy
);
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [NREQ-1:0]  r_gnt;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [SEL_W-1:0] w_pick;
    logic             w_valid;
    logic             w_beat;
    logic             w_release;
    logic             w_start;

    // First requester at or after ptr, scanning upward with wrap.
    function automatic logic [SEL_W-1:0] rr_pick(
        input logic [NREQ-1:0]  r,
        input logic [SEL_W-1:0] p
    );
        logic [SEL_W-1:0] idx;
        logic             found;
        rr_pick = p;
        found   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = p + SEL_W'(i);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    assign w_pick    = rr_pick(req, r_ptr);
    assign w_valid   = (r_state == GRANT) & req[r_sel];
    assign w_beat    = w_valid & out_ready;
    assign w_start   = (r_state == IDLE) & (|req);
    assign w_release = (r_state == GRANT)
                     & (~req[r_sel]
                     | (w_beat & (last[r_sel] | (r_cnt == CNT_LAST))));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (|req)     w_state_nxt = GRANT;
            GRANT:   if (w_release) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Grant, select, pointer and beat count advance with the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt <= '0;
            r_sel <= '0;
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (w_start) begin
            r_gnt <= NREQ'(1) << w_pick;
            r_sel <= w_pick;
            r_cnt <= '0;
        end else if (w_release) begin
            r_gnt <= '0;
            r_ptr <= r_sel + SEL_W'(1);
            r_cnt <= '0;
        end else if (w_beat) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        gnt       = r_gnt;
        out_sel   = r_sel;
        out_valid = w_valid;
        busy      = (r_state == GRANT);
    end

    mux4_data_sel #(.W(W)) u_data_sel (
        .sel      (r_sel),
        .data_in  (data_in),
        .out_data (out_data)
    );
endmodule
